uart_cfg: RTL and testbench

//  Runtime-configurable UART: baud generator, RX and TX engines, RX/TX FIFOs in one top.

---
 rtl/uart_cfg.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART with baud generator, RX/TX engines and
// RX/TX FWFT FIFOs. Divisor, parity (none/even/odd) and stop bits (1/2) are
// set at runtime and latched per frame when the frame's START state is entered.
// Optional build macro: UART_LOOPBACK_EN enables internal TX->RX loopback.

// Small FWFT FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic          rd,
    input  logic [W-1:0]  w_data,
    output logic [W-1:0]  r_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wptr, rptr;
    logic         do_wr, do_rd;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign level  = wptr - rptr;
    assign do_rd  = rd & ~empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO is then accepted.
    assign do_wr  = wr & (~full | rd);
    assign r_data = mem[rptr[AW-1:0]];

    // Pointer update; both ops may complete in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // Storage array, data only.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= w_data;
    end
endmodule

module uart_cfg #(
    parameter int DBIT     = 8,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          par_mode,
    input  logic                stop2,
    input  logic                rx,
    output logic                tx,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic                tx_idle,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_perr,
    output logic                rx_ferr,
    output logic                rx_empty,
    output logic                rx_ovr,
    input  logic                clr_ovr,
    input  logic                loopback
);
    localparam int NW    = $clog2(DBIT);
    localparam int LVL_W = FIFO_W + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic par_on(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    // Even: XOR of data; odd: its complement.
    function automatic logic par_bit(input logic [1:0] pm, input logic [DBIT-1:0] d);
        return (pm == 2'b10) ? ~(^d) : (^d);
    endfunction

    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;
    logic                tx_ser, rx_src, rx_s1, rx_sync;

    // Free-running 16x baud tick; >= lets a lowered divisor take effect at once.
    assign tick = (baud_cnt >= dvsr);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) baud_cnt <= '0;
        else          baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end

`ifdef UART_LOOPBACK_EN
    assign rx_src = loopback ? tx_ser : rx;
    assign tx     = loopback ? 1'b1 : tx_ser;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign rx_src = rx;
    assign tx     = tx_ser;
`endif

    // Two-flop synchronizer for the asynchronous serial input (idles high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {rx_sync, rx_s1} <= 2'b11;
        else          {rx_sync, rx_s1} <= {rx_s1, rx_src};
    end

    // ---------------- RX engine ----------------
    state_t            rx_state, rx_state_n;
    logic [4:0]        rx_s, rx_s_n;
    logic [NW-1:0]     rx_n, rx_n_n;
    logic [DBIT-1:0]   rx_b, rx_b_n;
    logic [1:0]        rx_pm, rx_pm_n;
    logic              rx_st2, rx_st2_n, rx_pe, rx_pe_n, rx_push, rx_full, rx_ovr_set;
    logic [DBIT+1:0]   rx_head;
    logic [FIFO_W:0]   unused_rx_level;

    // RX control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= IDLE; rx_s <= '0; rx_n <= '0;
            rx_pm <= 2'b00; rx_st2 <= 1'b0; rx_pe <= 1'b0;
        end else begin
            rx_state <= rx_state_n; rx_s <= rx_s_n; rx_n <= rx_n_n;
            rx_pm <= rx_pm_n; rx_st2 <= rx_st2_n; rx_pe <= rx_pe_n;
        end
    end

    // RX shift register, data only.
    always_ff @(posedge clk) rx_b <= rx_b_n;

    // RX next-state: mid-bit sampling at tick 7 of START, then every 16 ticks.
    always_comb begin
        rx_state_n = rx_state; rx_s_n = rx_s; rx_n_n = rx_n; rx_b_n = rx_b;
        rx_pm_n = rx_pm; rx_st2_n = rx_st2; rx_pe_n = rx_pe; rx_push = 1'b0;
        case (rx_state)
            IDLE: if (!rx_sync) begin
                rx_state_n = START; rx_s_n = '0; rx_pm_n = par_mode; rx_st2_n = stop2;
            end
            START: if (tick) begin
                if (rx_s == 5'd7) begin
                    if (rx_sync) rx_state_n = IDLE;
                    else begin rx_state_n = DATA; rx_s_n = '0; rx_n_n = '0; rx_pe_n = 1'b0; end
                end else rx_s_n = rx_s + 1'b1;
            end
            DATA: if (tick) begin
                if (rx_s == 5'd15) begin
                    rx_s_n = '0;
                    rx_b_n = {rx_sync, rx_b[DBIT-1:1]};
                    if (rx_n == NW'(DBIT-1)) rx_state_n = par_on(rx_pm) ? PARITY : STOP;
                    else                     rx_n_n = rx_n + 1'b1;
                end else rx_s_n = rx_s + 1'b1;
            end
            PARITY: if (tick) begin
                if (rx_s == 5'd15) begin
                    rx_s_n = '0; rx_state_n = STOP;
                    rx_pe_n = (rx_sync != par_bit(rx_pm, rx_b));
                end else rx_s_n = rx_s + 1'b1;
            end
            STOP: if (tick) begin
                if (rx_s == (rx_st2 ? 5'd31 : 5'd15)) begin
                    rx_push = 1'b1; rx_state_n = IDLE;
                end else rx_s_n = rx_s + 1'b1;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    uart_cfg_fifo #(.W(DBIT + 2), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .wr(rx_push), .rd(rd_uart),
        .w_data({~rx_sync, rx_pe, rx_b}), .r_data(rx_head),
        .full(rx_full), .empty(rx_empty), .level(unused_rx_level)
    );

    // Empty FIFO shows zeros rather than stale or uninitialised storage.
    assign r_data  = rx_empty ? '0   : rx_head[DBIT-1:0];
    assign rx_perr = rx_empty ? 1'b0 : rx_head[DBIT];
    assign rx_ferr = rx_empty ? 1'b0 : rx_head[DBIT+1];
    assign rx_ovr_set = rx_push & rx_full & ~rd_uart;

    // Sticky overrun flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        rx_ovr <= 1'b0;
        else if (rx_ovr_set) rx_ovr <= 1'b1;
        else if (clr_ovr)    rx_ovr <= 1'b0;
    end

    // ---------------- TX engine ----------------
    state_t            tx_state, tx_state_n;
    logic [4:0]        tx_s, tx_s_n;
    logic [NW-1:0]     tx_n, tx_n_n;
    logic [1:0]        tx_pm, tx_pm_n;
    logic              tx_st2, tx_st2_n, tx_pop, tx_bit, tx_empty;
    logic [DBIT-1:0]   tx_head;
    logic [FIFO_W:0]   tx_level;

    uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .wr(wr_uart), .rd(tx_pop),
        .w_data(w_data), .r_data(tx_head),
        .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    assign tx_idle = tx_empty && (tx_state == IDLE);

    // TX control state register; serial output idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= IDLE; tx_s <= '0; tx_n <= '0;
            tx_pm <= 2'b00; tx_st2 <= 1'b0; tx_ser <= 1'b1;
        end else begin
            tx_state <= tx_state_n; tx_s <= tx_s_n; tx_n <= tx_n_n;
            tx_pm <= tx_pm_n; tx_st2 <= tx_st2_n; tx_ser <= tx_bit;
        end
    end

    // TX next-state; the byte stays at the FIFO head until popped at STOP end.
    always_comb begin
        tx_state_n = tx_state; tx_s_n = tx_s; tx_n_n = tx_n;
        tx_pm_n = tx_pm; tx_st2_n = tx_st2; tx_pop = 1'b0; tx_bit = 1'b1;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_state_n = START; tx_s_n = '0; tx_pm_n = par_mode; tx_st2_n = stop2;
            end
            START: begin
                tx_bit = 1'b0;
                if (tick) begin
                    if (tx_s == 5'd15) begin tx_state_n = DATA; tx_s_n = '0; tx_n_n = '0; end
                    else tx_s_n = tx_s + 1'b1;
                end
            end
            DATA: begin
                tx_bit = tx_head[tx_n];
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n = '0;
                        if (tx_n == NW'(DBIT-1)) tx_state_n = par_on(tx_pm) ? PARITY : STOP;
                        else                     tx_n_n = tx_n + 1'b1;
                    end else tx_s_n = tx_s + 1'b1;
                end
            end
            PARITY: begin
                tx_bit = par_bit(tx_pm, tx_head);
                if (tick) begin
                    if (tx_s == 5'd15) begin tx_state_n = STOP; tx_s_n = '0; end
                    else tx_s_n = tx_s + 1'b1;
                end
            end
            STOP: if (tick) begin
                if (tx_s == (tx_st2 ? 5'd31 : 5'd15)) begin
                    tx_pop = 1'b1; tx_s_n = '0;
                    // Another byte behind the head: start it right after the pop.
                    if (tx_level > LVL_W'(1)) begin
                        tx_state_n = START; tx_pm_n = par_mode; tx_st2_n = stop2;
                    end else tx_state_n = IDLE;
                end else tx_s_n = tx_s + 1'b1;
            end
            default: tx_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_cfg.sv
// Testbench for uart_cfg: serial-line driver and TX-pin decoder modelled at
// the bit-time level, with expected values derived from the frame format.
module tb_uart_cfg;
    localparam int DBIT = 8, DVSR_BIT = 11, FIFO_W = 2;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [DVSR_BIT-1:0] dvsr = '0;
    logic [1:0] par_mode = 2'b00;
    logic stop2 = 1'b0, rx = 1'b1, tx, wr_uart = 1'b0, tx_full, tx_idle;
    logic [DBIT-1:0] w_data = '0, r_data;
    logic rd_uart = 1'b0, rx_perr, rx_ferr, rx_empty, rx_ovr, clr_ovr = 1'b0, loopback = 1'b0;

    always #5 clk = ~clk;

    uart_cfg #(.DBIT(DBIT), .DVSR_BIT(DVSR_BIT), .FIFO_W(FIFO_W)) dut (
        .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .par_mode(par_mode), .stop2(stop2),
        .rx(rx), .tx(tx), .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
        .tx_idle(tx_idle), .rd_uart(rd_uart), .r_data(r_data), .rx_perr(rx_perr),
        .rx_ferr(rx_ferr), .rx_empty(rx_empty), .rx_ovr(rx_ovr), .clr_ovr(clr_ovr),
        .loopback(loopback)
    );

    int checks = 0, failures = 0;
    int bp = 64;                        // clocks per serial bit
    logic [1:0] cur_pm = 2'b00;
    logic cur_st2 = 1'b0;
    int fall_cnt = 0;

    logic [7:0] mon_data[$];
    logic       mon_par[$];
    logic       mon_ok[$];
    logic [9:0] exp_rx[$];              // {ferr, perr, data}

    always @(negedge tx) fall_cnt <= fall_cnt + 1;

    // TX pin decoder: samples each bit in its middle using the current bit time.
    initial begin
        int b; logic [7:0] d; logic p, ok; logic [1:0] pm; logic st2;
        forever begin
            @(negedge tx);
            b = bp; pm = cur_pm; st2 = cur_st2; ok = 1'b1; p = 1'b0; d = '0;
            repeat (b / 2) @(negedge clk);
            if (tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (b) @(negedge clk);
                d[i] = tx;
            end
            if (pm == 2'b01 || pm == 2'b10) begin
                repeat (b) @(negedge clk);
                p = tx;
            end
            repeat (b) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
            if (st2) begin
                repeat (b) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
            end
            mon_data.push_back(d); mon_par.push_back(p); mon_ok.push_back(ok);
        end
    end

    function automatic logic exp_parity(input logic [1:0] pm, input logic [7:0] d);
        logic odd_ones;
        odd_ones = ($countones(d) % 2) == 1;
        return (pm == 2'b10) ? !odd_ones : odd_ones;
    endfunction

    task automatic set_cfg(input int dv, input logic [1:0] pm, input logic st2);
        dvsr = DVSR_BIT'(dv); par_mode = pm; stop2 = st2;
        bp = 16 * (dv + 1); cur_pm = pm; cur_st2 = st2;
    endtask

    task automatic write_byte(input logic [7:0] d);
        w_data = d; wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic read_pop();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    // Drives one frame on rx; a bad stop bit is held low only past its sample point.
    task automatic drive_frame(input logic [7:0] d, input logic [1:0] pm, input logic st2,
                               input logic bad_par, input logic bad_stop);
        logic pb; int tk;
        tk = bp / 16;
        rx = 1'b0; repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; repeat (bp) @(negedge clk);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            pb = exp_parity(pm, d) ^ bad_par;
            rx = pb; repeat (bp) @(negedge clk);
        end
        if (bad_stop) begin
            rx = 1'b0; repeat ((st2 ? bp : 0) + 12 * tk) @(negedge clk);
            rx = 1'b1; repeat (4 * tk) @(negedge clk);
        end else begin
            rx = 1'b1; repeat (st2 ? 2 * bp : bp) @(negedge clk);
        end
        rx = 1'b1; repeat (bp) @(negedge clk);
        exp_rx.push_back({bad_stop, bad_par & ((pm == 2'b01) || (pm == 2'b10)), d});
    endtask

    task automatic wait_frames(input int n, input int lim, input string name);
        int c = 0;
        while (mon_data.size() < n && c < lim) begin @(negedge clk); c++; end
        checks++;
        if (mon_data.size() < n) begin
            failures++;
            $display("FAIL %s frames got=%0d want=%0d", name, mon_data.size(), n);
        end
    endtask

    task automatic wait_tx_idle(input string name);
        int c = 0;
        while (tx_idle !== 1'b1 && c < 4000) begin @(negedge clk); c++; end
        checks++;
        if (tx_idle !== 1'b1) begin failures++; $display("FAIL %s tx_idle got=%b want=1", name, tx_idle); end
    endtask

    task automatic check_rx_queue(input string name);
        logic [9:0] e;
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || {rx_ferr, rx_perr, r_data} !== e) begin
                failures++;
                $display("FAIL %s entry got=%b_%b_%h empty=%b want=%b_%b_%h", name,
                         rx_ferr, rx_perr, r_data, rx_empty, e[9], e[8], e[7:0]);
            end
            read_pop();
        end
        checks++;
        if (rx_empty !== 1'b1) begin failures++; $display("FAIL %s drained rx_empty got=%b want=1", name, rx_empty); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, tx_full, tx_idle, rx_empty, rx_perr, rx_ferr, rx_ovr} !== 7'b1011000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=1011000",
                     {tx, tx_full, tx_idle, rx_empty, rx_perr, rx_ferr, rx_ovr});
        end
        checks++;
        if (r_data !== 8'h00) begin failures++; $display("FAIL reset_r_data got=%h want=00", r_data); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_basic();
        int c = 0, low = 0;
        set_cfg(3, 2'b00, 1'b0);
        mon_data.delete(); mon_par.delete(); mon_ok.delete();
        write_byte(8'hA5);
        while (tx !== 1'b0 && c < 20) begin @(negedge clk); c++; end
        while (tx === 1'b0 && low < 200) begin @(negedge clk); low++; end
        checks++;
        if (low < 61 || low > 64) begin failures++; $display("FAIL tx_start_len got=%0d want=61..64", low); end
        wait_frames(1, 2000, "tx_basic");
        if (mon_data.size() > 0) begin
            checks++;
            if (mon_data[0] !== 8'hA5 || mon_ok[0] !== 1'b1) begin
                failures++;
                $display("FAIL tx_basic_frame got=%h ok=%b want=a5 ok=1", mon_data[0], mon_ok[0]);
            end
        end
        wait_tx_idle("tx_basic");
    endtask

    task automatic test_tx_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        for (int r = 0; r < 2; r++) begin
            set_cfg($urandom_range(1, 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            mon_data.delete(); mon_par.delete(); mon_ok.delete(); exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                d = 8'($urandom); exp_q.push_back(d); write_byte(d);
            end
            checks++;
            if (tx_full !== 1'b1) begin failures++; $display("FAIL tx_full_after4 got=%b want=1", tx_full); end
            write_byte(8'($urandom));       // dropped: FIFO full
            wait_frames(4, 20000, "tx_random");
            for (int i = 0; i < 4 && i < mon_data.size(); i++) begin
                checks++;
                if (mon_data[i] !== exp_q[i] || mon_ok[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_rand_frame%0d got=%h ok=%b want=%h ok=1", i, mon_data[i], mon_ok[i], exp_q[i]);
                end
                if (cur_pm == 2'b01 || cur_pm == 2'b10) begin
                    checks++;
                    if (mon_par[i] !== exp_parity(cur_pm, exp_q[i])) begin
                        failures++;
                        $display("FAIL tx_rand_par%0d got=%b want=%b", i, mon_par[i], exp_parity(cur_pm, exp_q[i]));
                    end
                end
            end
            wait_tx_idle("tx_random");
            repeat (2 * bp) @(negedge clk);
            checks++;
            if (mon_data.size() != 4) begin failures++; $display("FAIL tx_rand_count got=%0d want=4", mon_data.size()); end
        end
    endtask

    task automatic test_rx_errors();
        set_cfg(2, 2'b10, 1'b0);
        drive_frame(8'h81, 2'b10, 1'b0, 1'b1, 1'b0);
        set_cfg(2, 2'b00, 1'b0);
        drive_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1);
        drive_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0);
        check_rx_queue("rx_errors");
    endtask

    task automatic test_rx_random();
        logic [1:0] pm; logic st2, bpar, bstop;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                pm = 2'($urandom_range(0, 3)); st2 = 1'($urandom_range(0, 1));
                bpar = 1'($urandom_range(0, 1)); bstop = ($urandom_range(0, 3) == 0);
                set_cfg($urandom_range(1, 3), pm, st2);
                drive_frame(8'($urandom), pm, st2, bpar, bstop);
            end
            check_rx_queue("rx_random");
        end
    endtask

    task automatic test_overrun();
        set_cfg(1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) drive_frame(8'($urandom), 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rx_ovr !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b want=0", rx_ovr); end
        drive_frame(8'($urandom), 2'b00, 1'b0, 1'b0, 1'b0);
        void'(exp_rx.pop_back());           // fifth frame is dropped
        checks++;
        if (rx_ovr !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", rx_ovr); end
        check_rx_queue("overrun");
        clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
        checks++;
        if (rx_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b want=0", rx_ovr); end
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback();
        int f0, c;
        logic [7:0] d;
        loopback = 1'b1;
        set_cfg(1, 2'b01, 1'b0);
        f0 = fall_cnt;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 8'h3C : 8'($urandom);
            write_byte(d);
            c = 0;
            while (rx_empty !== 1'b0 && c < 3000) begin @(negedge clk); c++; end
            checks++;
            if (rx_empty !== 1'b0 || {rx_ferr, rx_perr, r_data} !== {2'b00, d}) begin
                failures++;
                $display("FAIL loopback%0d got=%b_%b_%h empty=%b want=0_0_%h", i, rx_ferr, rx_perr, r_data, rx_empty, d);
            end
            read_pop();
            checks++;
            if (rx_empty !== 1'b1) begin failures++; $display("FAIL loopback_pop rx_empty got=%b want=1", rx_empty); end
            wait_tx_idle("loopback");
        end
        checks++;
        if (fall_cnt != f0) begin failures++; $display("FAIL loopback_pin tx_edges got=%0d want=0", fall_cnt - f0); end
        loopback = 1'b0;
        repeat (4) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        int f1;
        set_cfg(1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) write_byte(8'($urandom));
        repeat (480) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({tx, tx_idle, tx_full} !== 3'b110) begin
            failures++;
            $display("FAIL reset_mid got tx=%b idle=%b full=%b want tx=1 idle=1 full=0", tx, tx_idle, tx_full);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        f1 = fall_cnt;
        repeat (1200) @(negedge clk);
        checks++;
        if (fall_cnt != f1 || tx !== 1'b1 || tx_idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after edges=%0d tx=%b idle=%b want 0 1 1", fall_cnt - f1, tx, tx_idle);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_random();
        test_rx_errors();
        test_rx_random();
        test_overrun();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
